// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer
//   Drives an LFSR challenge sequence into a PUF core. Each challenge is held
//   for SETTLE cycles before the 1-bit response is sampled. N_RESP responses
//   are packed into resp_word, and the host consumes it with a valid/ack
//   handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a batch (accepted only when idle)
//   seed        initial challenge, captured on accepted start (0 -> 1)
//   challenge   challenge bus to the PUF
//   response    PUF response bit
//   busy        high from accepted start until the word is acked
//   resp_word   packed responses, bit i = response to challenge i
//   resp_valid  resp_word valid, held until resp_ack
//   resp_ack    host consumes resp_word
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; outputs hold
// S_SETTLE | challenge stable, settle down-counter running
// S_SAMPLE | capture response, advance LFSR, next challenge or finish
// S_DONE   | resp_word presented, waiting for resp_ack
module puf_crp_sequencer #(
    parameter int N_CB   = 64,
    parameter int N_RESP = 32,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_CB-1:0]   seed,
    output logic [N_CB-1:0]   challenge,
    input  logic              response,
    output logic              busy,
    output logic [N_RESP-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ack
);
    localparam int IDX_W = (N_RESP > 1) ? $clog2(N_RESP) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RESP - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [N_CB-1:0]   challenge_d;
    logic [N_RESP-1:0] resp_word_d;
    logic              resp_valid_d;
    logic              busy_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [CNT_W-1:0]  settle_cnt, settle_cnt_d;
    logic              fb;

    // x^64 + x^63 + x^61 + x^60 + 1
    assign fb = challenge[N_CB-1] ^ challenge[N_CB-2] ^ challenge[N_CB-4] ^ challenge[N_CB-5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            challenge  <= '0;
            resp_word  <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            challenge  <= challenge_d;
            resp_word  <= resp_word_d;
            resp_valid <= resp_valid_d;
            busy       <= busy_d;
            idx        <= idx_d;
            settle_cnt <= settle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        challenge_d  = challenge;
        resp_word_d  = resp_word;
        resp_valid_d = resp_valid;
        busy_d       = busy;
        idx_d        = idx;
        settle_cnt_d = settle_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // an all-zero seed would lock the LFSR at zero
                    challenge_d  = (seed == '0) ? N_CB'(1) : seed;
                    settle_cnt_d = CNT_LOAD;
                    idx_d        = '0;
                    resp_word_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                resp_word_d[idx] = response;
                challenge_d      = {challenge[N_CB-2:0], fb};
                if (idx == IDX_LAST) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    idx_d        = idx + IDX_W'(1);
                    settle_cnt_d = CNT_LOAD;
                    state_d      = S_SETTLE;
                end
            end
            S_DONE: begin
                // a start coinciding with the ack is dropped; host re-asserts
                if (resp_ack) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
module tb_puf_crp_sequencer;
    localparam int NR_A = 8;
    localparam int ST_A = 4;
    localparam int NR_B = 16;
    localparam int ST_B = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    logic             start_a = 1'b0;
    logic [63:0]      seed_a = '0;
    logic [63:0]      chal_a;
    logic             resp_a;
    logic             busy_a;
    logic [NR_A-1:0]  resp_word_a;
    logic             resp_valid_a;
    logic             resp_ack_a = 1'b0;
    logic [63:0]      mask_a = 64'h400;

    logic             start_b = 1'b0;
    logic [63:0]      seed_b = '0;
    logic [63:0]      chal_b;
    logic             resp_b;
    logic             busy_b;
    logic [NR_B-1:0]  resp_word_b;
    logic             resp_valid_b;
    logic             resp_ack_b = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // PUF models: A is a masked parity of the challenge, B is challenge[10]
    assign resp_a = ^(chal_a & mask_a);
    assign resp_b = chal_b[10];

    always #5 clk = ~clk;

    puf_crp_sequencer #(.N_CB(64), .N_RESP(NR_A), .SETTLE(ST_A)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .seed       (seed_a),
        .challenge  (chal_a),
        .response   (resp_a),
        .busy       (busy_a),
        .resp_word  (resp_word_a),
        .resp_valid (resp_valid_a),
        .resp_ack   (resp_ack_a)
    );

    puf_crp_sequencer #(.N_CB(64), .N_RESP(NR_B), .SETTLE(ST_B)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .seed       (seed_b),
        .challenge  (chal_b),
        .response   (resp_b),
        .busy       (busy_b),
        .resp_word  (resp_word_b),
        .resp_valid (resp_valid_b),
        .resp_ack   (resp_ack_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the LFSR sequence directly, one response per challenge.
    function automatic void model(input logic [63:0] s, input logic [63:0] m, input int n,
                                  output logic [63:0] word, output logic [63:0] fin);
        logic [63:0] c;
        c = (s == 64'd0) ? 64'd1 : s;
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[i] = ^(c & m);
            c = {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
        end
        fin = c;
    endfunction

    // Challenge stability: inside a batch every change must be SETTLE+1 edges after the last.
    int          gap;
    logic [63:0] prev_c;
    logic        prev_busy;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap       = 0;
            prev_c    = '0;
            prev_busy = 1'b0;
        end else begin
            gap++;
            if (chal_a !== prev_c) begin
                if (prev_busy) check("settle_gap", 64'(gap), 64'(ST_A + 1));
                gap = 0;
            end
            prev_c    = chal_a;
            prev_busy = busy_a;
        end
    end

    task automatic run_a(input logic [63:0] s, input logic [63:0] m, input bit noise, input bit do_ack,
                         output logic [63:0] word, output logic [63:0] fin, output int lat);
        mask_a = m;
        @(negedge clk);
        seed_a  = s;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        seed_a  = {$urandom, $urandom};
        check("first_chal", chal_a, (s == 64'd0) ? 64'd1 : s);
        lat = 0;
        while (resp_valid_a !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                start_a = ($urandom_range(0, 5) == 0);
                seed_a  = {$urandom, $urandom};
            end
        end
        start_a = 1'b0;
        word = 64'(resp_word_a);
        fin  = chal_a;
        if (do_ack) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            resp_ack_a = 1'b1;
            @(posedge clk);
            #1;
            resp_ack_a = 1'b0;
            check("ack_valid", 64'(resp_valid_a), 64'd0);
            check("ack_busy", 64'(busy_a), 64'd0);
        end
    endtask

    typedef struct {
        logic [63:0] seed;
        logic [63:0] mask;
        logic [7:0]  exp_word;
        logic [63:0] exp_chal;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [63:0] w, f, ew, ef;
        int lat;

        tbl[0] = '{64'h400, 64'h400, 8'h01, 64'h40000};
        tbl[1] = '{64'h7FF, 64'h400, 8'hFF, 64'h7FF00};
        tbl[2] = '{64'h0, 64'h400, 8'h00, 64'h100};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h01, 64'h80};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h01, 64'hFFFF_FFFF_FFFF_FF00};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 8'h03, 64'hFFFF_FFFF_FFFF_FF00};

        repeat (3) @(negedge clk);
        check("rst_chal", chal_a, 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_valid", 64'(resp_valid_a), 64'd0);
        check("rst_word", 64'(resp_word_a), 64'd0);
        rst_n = 1'b1;

        // asynchronous reset in the middle of SETTLE
        @(negedge clk);
        seed_a  = 64'h1234;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("pre_rst_busy", 64'(busy_a), 64'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_chal", chal_a, 64'd0);
        check("async_rst_busy", 64'(busy_a), 64'd0);
        check("async_rst_valid", 64'(resp_valid_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy_a), 64'd0);
        check("post_rst_chal", chal_a, 64'd0);

        // directed table
        for (int i = 0; i < 6; i++) begin
            run_a(tbl[i].seed, tbl[i].mask, 1'b0, 1'b1, w, f, lat);
            check("tbl_word", w, 64'(tbl[i].exp_word));
            check("tbl_chal", f, tbl[i].exp_chal);
            check("tbl_latency", 64'(lat), 64'(NR_A * (ST_A + 1)));
        end

        // DONE hold, start ignored, ack with simultaneous start
        model(64'h7FF, 64'h400, NR_A, ew, ef);
        run_a(64'h7FF, 64'h400, 1'b0, 1'b0, w, f, lat);
        check("hs_word", w, ew);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start_a = (k == 5);
            seed_a  = 64'hDEAD;
            @(posedge clk);
            #1;
            check("hs_valid_hold", 64'(resp_valid_a), 64'd1);
            check("hs_word_hold", 64'(resp_word_a), ew);
            check("hs_chal_hold", chal_a, ef);
            check("hs_busy_hold", 64'(busy_a), 64'd1);
        end
        @(negedge clk);
        start_a    = 1'b1;
        seed_a     = 64'h55;
        resp_ack_a = 1'b1;
        @(posedge clk);
        #1;
        check("hs_ack_valid", 64'(resp_valid_a), 64'd0);
        check("hs_ack_busy", 64'(busy_a), 64'd0);
        check("hs_ack_chal", chal_a, ef);
        @(negedge clk);
        start_a    = 1'b0;
        resp_ack_a = 1'b0;
        @(posedge clk);
        #1;
        check("hs_idle_busy", 64'(busy_a), 64'd0);
        check("hs_idle_chal", chal_a, ef);
        run_a(64'h400, 64'h400, 1'b0, 1'b1, w, f, lat);
        check("hs_restart_word", w, 64'h01);

        // randomized batches with stray start pulses
        for (int r = 0; r < 12; r++) begin
            logic [63:0] s, m;
            s = {$urandom, $urandom};
            if (r == 0) s = 64'd0;
            m = {$urandom, $urandom};
            model(s, m, NR_A, ew, ef);
            run_a(s, m, 1'b1, 1'b1, w, f, lat);
            check("rnd_word", w, ew);
            check("rnd_chal", f, ef);
            check("rnd_latency", 64'(lat), 64'(NR_A * (ST_A + 1)));
        end

        // zero seed, 16 responses, SETTLE=1
        @(negedge clk);
        seed_b  = 64'd0;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check("b_first_chal", chal_b, 64'd1);
        lat = 0;
        while (resp_valid_b !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b_latency", 64'(lat), 64'd32);
        check("b_word", 64'(resp_word_b), 64'h0400);
        check("b_chal", chal_b, 64'h10000);
        @(negedge clk);
        resp_ack_b = 1'b1;
        @(posedge clk);
        #1;
        resp_ack_b = 1'b0;
        check("b_ack_valid", 64'(resp_valid_b), 64'd0);
        check("b_ack_busy", 64'(busy_b), 64'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
